// File: rtl/ei_axi4_slave_mem.sv
// AXI4 slave memory responder: byte-addressable RAM with FIXED/INCR/WRAP bursts,
// byte strobes and OKAY/SLVERR responses; independent write and read engines.
module ei_axi4_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_BYTES  = 4096
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]              awlen,
    input  logic [2:0]              awsize,
    input  logic [1:0]              awburst,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]              arlen,
    input  logic [2:0]              arsize,
    input  logic [1:0]              arburst,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rlast,
    output logic                    rvalid,
    input  logic                    rready
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int MEM_AW    = $clog2(MEM_BYTES);

    localparam logic [2:0] MAX_SIZE    = 3'(LANE_BITS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [7:0] mem [MEM_BYTES];

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    // Reserved bursts and illegal wrap lengths fall back to INCR stepping.
    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        if (burst == 2'b11 || (burst == BURST_WRAP && !wrap_len_ok(len)))
            return BURST_INCR;
        return burst;
    endfunction

    function automatic logic hdr_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        return (size > MAX_SIZE) || (burst == 2'b11) ||
               (burst == BURST_WRAP && !wrap_len_ok(len));
    endfunction

    function automatic logic beyond_mem(input logic [ADDR_WIDTH-1:0] addr);
        return |(addr >> MEM_AW);
    endfunction

    function automatic logic [MEM_AW-1:0] word_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr[MEM_AW-1:0] & ~MEM_AW'(BYTES - 1);
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic [ADDR_WIDTH-1:0] nxt;
        step      = ADDR_WIDTH'(1) << size;
        wrap_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_WRAP:  nxt = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
            default:     nxt = addr + step;
        endcase
        return nxt;
    endfunction

    // ---------------- write engine ----------------
    w_state_t              w_state, w_next;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_beat;
    logic                  w_err;
    logic                  aw_hs, w_hs, w_beat_err;
    logic [MEM_AW-1:0]     w_base;

    assign aw_hs      = awvalid && awready;
    assign w_hs       = wvalid && wready;
    assign w_base     = word_base(w_addr);
    assign w_beat_err = beyond_mem(w_addr) || (wlast != (w_beat == w_len));
    assign bresp      = (bvalid && w_err) ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge aclk) begin
        if (areset) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_comb begin
        w_next  = w_state;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        if (!areset) begin
            case (w_state)
                W_IDLE: begin
                    awready = 1'b1;
                    if (awvalid) w_next = W_DATA;
                end
                W_DATA: begin
                    wready = 1'b1;
                    if (wvalid && w_beat == w_len) w_next = W_RESP;
                end
                W_RESP: begin
                    bvalid = 1'b1;
                    if (bready) w_next = W_IDLE;
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= BURST_INCR;
            w_beat  <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= eff_burst(awburst, awlen);
            w_beat  <= '0;
            w_err   <= hdr_err(awsize, awburst, awlen);
        end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_len, w_size, w_burst);
            w_beat  <= w_beat + 8'd1;
            w_err   <= w_err || w_beat_err;
        end
    end

    // Out-of-range beats are dropped; memory is never cleared by reset.
    always_ff @(posedge aclk) begin
        if (w_hs && !beyond_mem(w_addr)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) mem[w_base | MEM_AW'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t              r_state, r_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat;
    logic                  r_err;
    logic                  ar_hs, r_hs, ld_en;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [7:0]            ld_beat, ld_len;
    logic                  ld_hdr_err;
    logic [MEM_AW-1:0]     ld_base;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign ld_en   = ar_hs || (r_hs && !rlast);
    assign ld_base = word_base(ld_addr);

    always_ff @(posedge aclk) begin
        if (areset) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_comb begin
        r_next  = r_state;
        arready = 1'b0;
        rvalid  = 1'b0;
        if (!areset) begin
            case (r_state)
                R_IDLE: begin
                    arready = 1'b1;
                    if (arvalid) r_next = R_DATA;
                end
                R_DATA: begin
                    rvalid = 1'b1;
                    if (rready && rlast) r_next = R_IDLE;
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // Beat 0 comes straight from the AR fields; later beats step the latched address.
    always_comb begin
        if (r_state == R_IDLE) begin
            ld_addr    = araddr;
            ld_beat    = '0;
            ld_len     = arlen;
            ld_hdr_err = hdr_err(arsize, arburst, arlen);
        end else begin
            ld_addr    = next_addr(r_addr, r_len, r_size, r_burst);
            ld_beat    = r_beat + 8'd1;
            ld_len     = r_len;
            ld_hdr_err = r_err;
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            rd_word[8*i +: 8] = mem[ld_base | MEM_AW'(i)];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= BURST_INCR;
            r_beat  <= '0;
            r_err   <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else begin
            if (ar_hs) begin
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= eff_burst(arburst, arlen);
                r_err   <= ld_hdr_err;
            end
            if (ld_en) begin
                r_addr <= ld_addr;
                r_beat <= ld_beat;
                rdata  <= beyond_mem(ld_addr) ? '0 : rd_word;
                rresp  <= (beyond_mem(ld_addr) || ld_hdr_err) ? RESP_SLVERR : RESP_OKAY;
                rlast  <= (ld_beat == ld_len);
            end
        end
    end

endmodule

// File: tb/tb_ei_axi4_slave_mem.sv
// Directed self-checking bench for ei_axi4_slave_mem: bursts, strobes, errors,
// backpressure and mid-burst reset.
module tb_ei_axi4_slave_mem;

    localparam int MB = 4096;

    logic        aclk, areset;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int assert_count = 0;
    int fail_count   = 0;

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    int          bad_last_beat = -1;
    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [1:0]  b_resp;

    ei_axi4_slave_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_BYTES(MB)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // All bus tasks start and end on a falling edge.
    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        int n;
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin
            assert_count++; fail_count++;
            $display("[TB] FAIL aw_timeout: awready=%b required 1", awready);
        end
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            wdata  = wr_data[b];
            wstrb  = wr_strb[b];
            wlast  = (b == int'(len)) ^ (b == bad_last_beat);
            wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
            if (n >= 50) begin
                assert_count++; fail_count++;
                $display("[TB] FAIL w_timeout beat %0d: wready=%b required 1", b, wready);
            end
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin
            assert_count++; fail_count++;
            $display("[TB] FAIL b_timeout: bvalid=%b required 1", bvalid);
        end
        b_resp = bresp;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
        if (n >= 50) begin
            assert_count++; fail_count++;
            $display("[TB] FAIL ar_timeout: arready=%b required 1", arready);
        end
        @(negedge aclk);
        arvalid = 1'b0;
        rready  = 1'b1;
        for (int b = 0; b <= int'(len); b++) begin
            n = 0;
            while (rvalid !== 1'b1 && n < 50) begin @(negedge aclk); n++; end
            if (n >= 50) begin
                assert_count++; fail_count++;
                $display("[TB] FAIL r_timeout beat %0d: rvalid=%b required 1", b, rvalid);
            end
            rd_data[b] = rdata;
            rd_resp[b] = rresp;
            rd_last[b] = rlast;
            @(negedge aclk);
        end
        rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        assert_count++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast} !== 42'd0) begin
            fail_count++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast});
        end
        areset = 1'b0;
        @(negedge aclk);
        assert_count++;
        if (awready !== 1'b1) begin
            fail_count++; $display("[TB] FAIL reset_awready: got %b required 1", awready);
        end
        assert_count++;
        if (arready !== 1'b1) begin
            fail_count++; $display("[TB] FAIL reset_arready: got %b required 1", arready);
        end
    endtask

    task automatic test_incr_write_read();
        for (int i = 0; i < 4; i++) begin wr_data[i] = 32'hA0 + 32'(i); wr_strb[i] = 4'hF; end
        do_write(32'h10, 8'd3, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b00) begin
            fail_count++; $display("[TB] FAIL incr_bresp: got %b required 00", b_resp);
        end
        assert_count++;
        if (awready !== 1'b1) begin
            fail_count++; $display("[TB] FAIL incr_awready_after_b: got %b required 1", awready);
        end
        do_read(32'h10, 8'd3, 3'd2, 2'b01);
        for (int b = 0; b < 4; b++) begin
            assert_count++;
            if (rd_data[b] !== 32'hA0 + 32'(b) || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 3)) begin
                fail_count++;
                $display("[TB] FAIL incr_read beat %0d: got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
                         b, rd_data[b], rd_resp[b], rd_last[b], 32'hA0 + 32'(b), (b == 3));
            end
        end
        assert_count++;
        if (arready !== 1'b1) begin
            fail_count++; $display("[TB] FAIL incr_arready_after_r: got %b required 1", arready);
        end
    endtask

    task automatic test_wrap_read();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h10E; exp_w[1] = 32'h10F; exp_w[2] = 32'h10C; exp_w[3] = 32'h10D;
        for (int i = 0; i < 16; i++) begin wr_data[i] = 32'h100 + 32'(i); wr_strb[i] = 4'hF; end
        do_write(32'h0, 8'd15, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b00) begin
            fail_count++; $display("[TB] FAIL fill_bresp: got %b required 00", b_resp);
        end
        do_read(32'h38, 8'd3, 3'd2, 2'b10);
        for (int b = 0; b < 4; b++) begin
            assert_count++;
            if (rd_data[b] !== exp_w[b] || rd_resp[b] !== 2'b00 || rd_last[b] !== (b == 3)) begin
                fail_count++;
                $display("[TB] FAIL wrap_read beat %0d: got data=%h resp=%b last=%b required data=%h resp=00 last=%b",
                         b, rd_data[b], rd_resp[b], rd_last[b], exp_w[b], (b == 3));
            end
        end
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
        do_write(32'h0, 8'd0, 3'd2, 2'b01);
        wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'h2;
        do_write(32'h0, 8'd0, 3'd2, 2'b01);
        do_read(32'h0, 8'd0, 3'd2, 2'b01);
        assert_count++;
        if (rd_data[0] !== 32'h1122FF44 || rd_last[0] !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL strobe_read: got data=%h last=%b required data=1122ff44 last=1",
                     rd_data[0], rd_last[0]);
        end
    endtask

    task automatic test_out_of_range();
        wr_data[0] = 32'hDEADBEEF; wr_data[1] = 32'hCAFEF00D;
        wr_strb[0] = 4'hF;         wr_strb[1] = 4'hF;
        do_write(32'(MB - 4), 8'd1, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b10) begin
            fail_count++; $display("[TB] FAIL oor_bresp: got %b required 10", b_resp);
        end
        do_read(32'(MB - 4), 8'd1, 3'd2, 2'b01);
        assert_count++;
        if (rd_data[0] !== 32'hDEADBEEF || rd_resp[0] !== 2'b00) begin
            fail_count++;
            $display("[TB] FAIL oor_beat0: got data=%h resp=%b required data=deadbeef resp=00",
                     rd_data[0], rd_resp[0]);
        end
        assert_count++;
        if (rd_data[1] !== 32'h0 || rd_resp[1] !== 2'b10 || rd_last[1] !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL oor_beat1: got data=%h resp=%b last=%b required data=0 resp=10 last=1",
                     rd_data[1], rd_resp[1], rd_last[1]);
        end
    endtask

    task automatic test_fixed_and_errors();
        for (int i = 0; i < 3; i++) begin wr_data[i] = 32'(i + 1); wr_strb[i] = 4'hF; end
        do_write(32'h80, 8'd2, 3'd2, 2'b00);
        do_read(32'h80, 8'd0, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b00 || rd_data[0] !== 32'h3) begin
            fail_count++;
            $display("[TB] FAIL fixed_write: got bresp=%b data=%h required bresp=00 data=3", b_resp, rd_data[0]);
        end
        do_read(32'h0, 8'd1, 3'd2, 2'b11);
        assert_count++;
        if (rd_data[1] !== 32'h101 || rd_resp[0] !== 2'b10 || rd_resp[1] !== 2'b10) begin
            fail_count++;
            $display("[TB] FAIL reserved_burst: got data1=%h resp=%b/%b required data1=101 resp=10/10",
                     rd_data[1], rd_resp[0], rd_resp[1]);
        end
        do_read(32'h0, 8'd2, 3'd2, 2'b10);
        assert_count++;
        if (rd_data[2] !== 32'h102 || rd_resp[0] !== 2'b10 || rd_resp[2] !== 2'b10) begin
            fail_count++;
            $display("[TB] FAIL bad_wrap_len: got data2=%h resp=%b/%b required data2=102 resp=10/10",
                     rd_data[2], rd_resp[0], rd_resp[2]);
        end
        do_read(32'h0, 8'd0, 3'd3, 2'b01);
        assert_count++;
        if (rd_resp[0] !== 2'b10) begin
            fail_count++; $display("[TB] FAIL oversize_read: got resp=%b required 10", rd_resp[0]);
        end
        wr_data[0] = 32'h5; wr_data[1] = 32'h6; wr_strb[0] = 4'hF; wr_strb[1] = 4'hF;
        bad_last_beat = 1;
        do_write(32'h90, 8'd1, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b10) begin
            fail_count++; $display("[TB] FAIL missing_wlast: got bresp=%b required 10", b_resp);
        end
        bad_last_beat = 0;
        do_write(32'hA0, 8'd1, 3'd2, 2'b01);
        bad_last_beat = -1;
        assert_count++;
        if (b_resp !== 2'b10) begin
            fail_count++; $display("[TB] FAIL early_wlast: got bresp=%b required 10", b_resp);
        end
        do_read(32'hA0, 8'd1, 3'd2, 2'b01);
        assert_count++;
        if (rd_data[0] !== 32'h5 || rd_data[1] !== 32'h6) begin
            fail_count++;
            $display("[TB] FAIL early_wlast_data: got %h/%h required 5/6", rd_data[0], rd_data[1]);
        end
    endtask

    task automatic test_backpressure();
        araddr = 32'h0; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        rready  = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            assert_count++;
            if (rvalid !== 1'b1 || rdata !== 32'h101 || rlast !== 1'b0 || rresp !== 2'b00) begin
                fail_count++;
                $display("[TB] FAIL stall_cycle %0d: got valid=%b data=%h last=%b resp=%b required valid=1 data=101 last=0 resp=00",
                         c, rvalid, rdata, rlast, rresp);
            end
            @(negedge aclk);
        end
        rready = 1'b1;
        @(negedge aclk);
        assert_count++;
        if (rdata !== 32'h102 || rlast !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL stall_beat2: got data=%h last=%b required data=102 last=0", rdata, rlast);
        end
        @(negedge aclk);
        assert_count++;
        if (rdata !== 32'h103 || rlast !== 1'b1 || rvalid !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL stall_beat3: got data=%h last=%b valid=%b required data=103 last=1 valid=1",
                     rdata, rlast, rvalid);
        end
        @(negedge aclk);
        rready = 1'b0;
        assert_count++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
            fail_count++;
            $display("[TB] FAIL stall_end: got rvalid=%b arready=%b required rvalid=0 arready=1", rvalid, arready);
        end
    endtask

    task automatic test_reset_mid_write();
        awaddr = 32'h200; awlen = 8'd3; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        assert_count++;
        if (wready !== 1'b1 || awready !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL aw_to_w_latency: got wready=%b awready=%b required wready=1 awready=0",
                     wready, awready);
        end
        wdata = 32'h55; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(negedge aclk);
        wvalid = 1'b0;
        areset = 1'b1;
        @(negedge aclk);
        assert_count++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast} !== 42'd0) begin
            fail_count++;
            $display("[TB] FAIL midreset_outputs: got %h required 0",
                     {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast});
        end
        areset = 1'b0;
        @(negedge aclk);
        assert_count++;
        if (awready !== 1'b1 || wready !== 1'b0 || bvalid !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL midreset_recover: got awready=%b wready=%b bvalid=%b required 1/0/0",
                     awready, wready, bvalid);
        end
        wr_data[0] = 32'h600DF00D; wr_strb[0] = 4'hF;
        do_write(32'h200, 8'd0, 3'd2, 2'b01);
        do_read(32'h200, 8'd0, 3'd2, 2'b01);
        assert_count++;
        if (b_resp !== 2'b00 || rd_data[0] !== 32'h600DF00D) begin
            fail_count++;
            $display("[TB] FAIL post_reset_xfer: got bresp=%b data=%h required bresp=00 data=600df00d",
                     b_resp, rd_data[0]);
        end
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        @(negedge aclk);
        $display("[TB] starting directed tests");
        test_reset();
        test_incr_write_read();
        test_wrap_read();
        test_strobe();
        test_out_of_range();
        test_fixed_and_errors();
        test_backpressure();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
